// File: rtl/serial_add_ctrl.sv
`default_nettype none
// ============================================================================
// Module   : serial_add_ctrl
// Brief    : Bit-serial LSB-first adder sequencer (start/busy/done) built on a
//            single full-adder cell; optional subtract mode via SERIAL_ADD_SUB_EN.
// Revision : 1.0
// ============================================================================

module serial_add_ctrl_fa (
  input  logic a,
  input  logic b,
  input  logic ci,
  output logic s,
  output logic co
);
  assign s  = a ^ b ^ ci;
  assign co = (a & b) | (ci & (a ^ b));
endmodule

module serial_add_ctrl #(
  parameter int WIDTH = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             cin,
`ifdef SERIAL_ADD_SUB_EN
  input  logic             sub,
`endif
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] sum,
  output logic             cout
);

  localparam int CNT_W = $clog2(WIDTH + 1);
  localparam logic [CNT_W-1:0] c_last_bit = CNT_W'(WIDTH - 1);

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_SHIFT = 2'd1,
    ST_DONE  = 2'd2
  } state_t;

  state_t           state_q,  state_d;
  logic [WIDTH-1:0] op_a_q,   op_a_d;
  logic [WIDTH-1:0] op_b_q,   op_b_d;
  logic [WIDTH-1:0] result_q, result_d;
  logic [WIDTH-1:0] sum_q,    sum_d;
  logic             carry_q,  carry_d;
  logic             cout_q,   cout_d;
  logic [CNT_W-1:0] cnt_q,    cnt_d;

  logic fa_b;
  logic fa_s;
  logic fa_co;

`ifdef SERIAL_ADD_SUB_EN
  logic sub_q, sub_d;
  // Subtraction is a + ~b + 1: invert B at the cell input, seed carry with 1.
  assign fa_b = op_b_q[0] ^ sub_q;
`else
  assign fa_b = op_b_q[0];
`endif

  serial_add_ctrl_fa u_fa (
    .a  (op_a_q[0]),
    .b  (fa_b),
    .ci (carry_q),
    .s  (fa_s),
    .co (fa_co)
  );

  always_comb begin
    state_d  = state_q;
    op_a_d   = op_a_q;
    op_b_d   = op_b_q;
    result_d = result_q;
    sum_d    = sum_q;
    carry_d  = carry_q;
    cout_d   = cout_q;
    cnt_d    = cnt_q;
`ifdef SERIAL_ADD_SUB_EN
    sub_d    = sub_q;
`endif

    unique case (state_q)
      ST_IDLE: begin
        if (start) begin
          op_a_d   = a;
          op_b_d   = b;
          result_d = '0;
          cnt_d    = '0;
`ifdef SERIAL_ADD_SUB_EN
          sub_d    = sub;
          carry_d  = sub ? 1'b1 : cin;
`else
          carry_d  = cin;
`endif
          state_d  = ST_SHIFT;
        end
      end

      ST_SHIFT: begin
        result_d = (result_q >> 1) | ({{(WIDTH-1){1'b0}}, fa_s} << (WIDTH - 1));
        carry_d  = fa_co;
        op_a_d   = op_a_q >> 1;
        op_b_d   = op_b_q >> 1;
        cnt_d    = cnt_q + CNT_W'(1);
        // Publish on the final bit so sum/cout are valid in the DONE cycle.
        if (cnt_q == c_last_bit) begin
          sum_d   = result_d;
          cout_d  = fa_co;
          state_d = ST_DONE;
        end
      end

      ST_DONE: begin
        state_d = ST_IDLE;
      end

      default: begin
        state_d = ST_IDLE;
      end
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q  <= ST_IDLE;
      op_a_q   <= '0;
      op_b_q   <= '0;
      result_q <= '0;
      sum_q    <= '0;
      carry_q  <= 1'b0;
      cout_q   <= 1'b0;
      cnt_q    <= '0;
`ifdef SERIAL_ADD_SUB_EN
      sub_q    <= 1'b0;
`endif
    end else begin
      state_q  <= state_d;
      op_a_q   <= op_a_d;
      op_b_q   <= op_b_d;
      result_q <= result_d;
      sum_q    <= sum_d;
      carry_q  <= carry_d;
      cout_q   <= cout_d;
      cnt_q    <= cnt_d;
`ifdef SERIAL_ADD_SUB_EN
      sub_q    <= sub_d;
`endif
    end
  end

  assign busy = (state_q == ST_SHIFT);
  assign done = (state_q == ST_DONE);
  assign sum  = sum_q;
  assign cout = cout_q;

endmodule
`default_nettype wire

// File: tb/tb_serial_add_ctrl.sv
`default_nettype none
// ============================================================================
// Module   : tb_serial_add_ctrl
// Brief    : Self-checking bench for serial_add_ctrl against an arithmetic model.
// Revision : 1.0
// ============================================================================

module tb_serial_add_ctrl;

  localparam int W = 8;

  logic         clk = 1'b0;
  logic         rst;
  logic         start;
  logic [W-1:0] a;
  logic [W-1:0] b;
  logic         cin;
  logic         busy;
  logic         done;
  logic [W-1:0] sum;
  logic         cout;
`ifdef SERIAL_ADD_SUB_EN
  logic         sub;
`endif

  int         n_tests = 0;
  int         n_fail  = 0;
  logic [W:0] model_prev;

  always #5 clk = ~clk;

  serial_add_ctrl #(.WIDTH(W)) dut (
    .clk   (clk),
    .rst   (rst),
    .start (start),
    .a     (a),
    .b     (b),
    .cin   (cin),
`ifdef SERIAL_ADD_SUB_EN
    .sub   (sub),
`endif
    .busy  (busy),
    .done  (done),
    .sum   (sum),
    .cout  (cout)
  );

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string tag, input logic [W:0] obs, input logic [W:0] exp);
    n_tests++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // One operation: start pulse, then observe a fixed window of cycles.
  task automatic do_op(input logic [W-1:0] a_i, input logic [W-1:0] b_i,
                       input logic cin_i, input logic sub_i,
                       input logic repulse, input string tag);
    logic [W:0] exp;
    logic [W:0] got;
    int         done_cyc;
    int         busy_cnt;
    int         dones;
    logic       overlap;
    logic       hold_bad;

    if (sub_i)
      exp = {(a_i >= b_i), W'(a_i - b_i)};
    else
      exp = {1'b0, a_i} + {1'b0, b_i} + {{W{1'b0}}, cin_i};

    a     = a_i;
    b     = b_i;
    cin   = cin_i;
`ifdef SERIAL_ADD_SUB_EN
    sub   = sub_i;
`endif
    start = 1'b1;
    tick;
    start = 1'b0;
    a     = W'($urandom);
    b     = W'($urandom);
    cin   = 1'($urandom);

    done_cyc = 0;
    busy_cnt = 0;
    dones    = 0;
    overlap  = 1'b0;
    hold_bad = 1'b0;
    got      = '0;

    for (int c = 1; c <= W + 3; c++) begin
      if (busy) busy_cnt++;
      if (busy && ({cout, sum} !== model_prev)) hold_bad = 1'b1;
      if (busy && done) overlap = 1'b1;
      if (done) begin
        dones++;
        if (done_cyc == 0) begin
          done_cyc = c;
          got      = {cout, sum};
        end
      end
      // Re-request during SHIFT and during DONE; both must be ignored.
      start = repulse && (c == 3 || c == W + 1);
      if (start) begin
        a = W'(1);
        b = W'(1);
      end
      tick;
    end
    start = 1'b0;

    check({tag, " result"},    got, exp);
    check({tag, " done_cyc"},  (W+1)'(done_cyc), (W+1)'(W + 1));
    check({tag, " busy_cnt"},  (W+1)'(busy_cnt), (W+1)'(W));
    check({tag, " done_cnt"},  (W+1)'(dones), (W+1)'(1));
    check({tag, " overlap"},   (W+1)'(overlap), '0);
    check({tag, " hold_prev"}, (W+1)'(hold_bad), '0);
    check({tag, " held_after"}, {cout, sum}, exp);
    model_prev = exp;
  endtask

  initial begin
    rst   = 1'b1;
    start = 1'b0;
    a     = '0;
    b     = '0;
    cin   = 1'b0;
`ifdef SERIAL_ADD_SUB_EN
    sub   = 1'b0;
`endif
    model_prev = '0;

    tick;
    tick;
    check("reset busy", (W+1)'(busy), '0);
    check("reset done", (W+1)'(done), '0);
    check("reset sum",  (W+1)'(sum),  '0);
    check("reset cout", (W+1)'(cout), '0);
    rst = 1'b0;
    tick;

    do_op(8'h5A, 8'h3C, 1'b0, 1'b0, 1'b0, "add_5a_3c");
    do_op(8'hFF, 8'h01, 1'b0, 1'b0, 1'b1, "repulse_ff_01");
    do_op(8'hFF, 8'hFF, 1'b1, 1'b0, 1'b0, "add_ff_ff_1");

    // Abort in the fourth busy cycle; outputs clear without waiting for a clock.
    a     = 8'h11;
    b     = 8'h22;
    cin   = 1'b0;
    start = 1'b1;
    tick;
    start = 1'b0;
    tick;
    tick;
    tick;
    check("abort busy_before", (W+1)'(busy), (W+1)'(1));
    #1 rst = 1'b1;
    #1;
    check("abort busy", (W+1)'(busy), '0);
    check("abort done", (W+1)'(done), '0);
    check("abort sum",  (W+1)'(sum),  '0);
    check("abort cout", (W+1)'(cout), '0);
    tick;
    rst = 1'b0;
    tick;
    check("abort no_done", (W+1)'(done), '0);
    check("abort idle",    (W+1)'(busy), '0);
    model_prev = '0;

    do_op(8'h03, 8'h04, 1'b0, 1'b0, 1'b0, "after_abort");

`ifdef SERIAL_ADD_SUB_EN
    do_op(8'h10, 8'h01, 1'b0, 1'b1, 1'b0, "sub_10_01");
    do_op(8'h01, 8'h02, 1'b1, 1'b1, 1'b0, "sub_01_02");
`endif

    for (int i = 0; i < 40; i++) begin
`ifdef SERIAL_ADD_SUB_EN
      do_op(W'($urandom), W'($urandom), 1'($urandom), 1'($urandom), 1'($urandom), "rand");
`else
      do_op(W'($urandom), W'($urandom), 1'($urandom), 1'b0, 1'($urandom), "rand");
`endif
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
`default_nettype wire
